// File: rtl/ring_timed_multiplier.sv
// Unsigned 4x4 shift-and-add multiplier sequenced by a one-hot 6-phase ring counter:
// T5 loads, T4..T1 each do one add/shift step, T0 stores the product.
module ring_timed_multiplier #(
   parameter bit CHECK_ONEHOT = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] T,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] product,
   output logic       err
);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   typedef enum logic [1:0] {
      PH_NONE,
      PH_LOAD,
      PH_STEP,
      PH_STORE
   } phase_t;

   state_t     state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] q_q, q_d;
   logic [3:0] acc_q, acc_d;
   logic       c_q, c_d;
   logic [7:0] product_q, product_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic       legal;
   phase_t     phase;
   logic [4:0] sum;

   // With checking disabled every pattern is treated as legal and the
   // priority decode below resolves multi-hot inputs.
   assign legal = CHECK_ONEHOT ? $onehot(T) : 1'b1;

   always_comb begin
      phase = PH_NONE;
      if (T[5])        phase = PH_LOAD;
      else if (|T[4:1]) phase = PH_STEP;
      else if (T[0])   phase = PH_STORE;
   end

   // C is always zero entering a step, so {C,ACC}+A equals the 5-bit ACC+A.
   assign sum = q_q[0] ? ({c_q, acc_q} + {1'b0, a_q}) : {c_q, acc_q};

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      acc_d     = acc_q;
      c_d       = c_q;
      product_d = product_q;
      done_d    = 1'b0;
      err_d     = err_q;

      if (!legal) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (phase == PH_LOAD && start) begin
                  a_d     = a;
                  q_d     = b;
                  acc_d   = 4'd0;
                  c_d     = 1'b0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               case (phase)
                  PH_LOAD: begin
                     // Ring restarted mid-operation: abandon without a result.
                     state_d = S_IDLE;
                     if (CHECK_ONEHOT) err_d = 1'b1;
                  end
                  PH_STEP: {c_d, acc_d, q_d} = {sum, q_q} >> 1;
                  PH_STORE: begin
                     product_d = {acc_q, q_q};
                     done_d    = 1'b1;
                     state_d   = S_IDLE;
                  end
                  default: ;
               endcase
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         a_q       <= 4'd0;
         q_q       <= 4'd0;
         acc_q     <= 4'd0;
         c_q       <= 1'b0;
         product_q <= 8'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together on the edge.
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         acc_q     <= acc_d;
         c_q       <= c_d;
         product_q <= product_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign busy    = (state_q == S_RUN);
   assign done    = done_q;
   assign product = product_q;
   assign err     = CHECK_ONEHOT ? err_q : 1'b0;

endmodule

// File: tb/tb_ring_timed_multiplier.sv
// Directed bench for ring_timed_multiplier; a checking and a non-checking
// instance share the same stimulus.
module tb_ring_timed_multiplier;

   logic       clk = 1'b0;
   logic       rstn;
   logic [5:0] T;
   logic       start;
   logic [3:0] a, b;
   logic       busy, done, err;
   logic [7:0] product;
   logic       busy0, done0, err0;
   logic [7:0] product0;

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   int t_first;

   always #5 clk = ~clk;

   ring_timed_multiplier #(.CHECK_ONEHOT(1'b1)) dut (
      .clk(clk), .rstn(rstn), .T(T), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product), .err(err)
   );

   ring_timed_multiplier #(.CHECK_ONEHOT(1'b0)) dut0 (
      .clk(clk), .rstn(rstn), .T(T), .start(start), .a(a), .b(b),
      .busy(busy0), .done(done0), .product(product0), .err(err0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: sample point is 1 time unit after the edge, then the ring advances.
   task automatic cyc();
      @(posedge clk);
      #1;
      cycle++;
      T = {T[0], T[5:1]};
   endtask

   task automatic wait_t5();
      for (int i = 0; i < 6 && T != 6'b100000; i++) cyc();
   endtask

   task automatic run_mult(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp,
                           input string tag);
      wait_t5();
      a = x; b = y; start = 1'b1;
      cyc();
      start = 1'b0;
      check({tag, "_busy_e0"}, busy, 1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check({tag, "_busy"}, busy, 1);
         check({tag, "_done_early"}, done, 0);
      end
      cyc();
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_product"}, product, exp);
      check({tag, "_product_nochk"}, product0, exp);
      cyc();
      check({tag, "_done_width"}, done, 0);
      check({tag, "_product_hold"}, product, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; T = 6'b100000; start = 1'b1; a = 4'd13; b = 4'd11;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // First edge after reset is T5: 13 x 11 accepted immediately.
      cyc();
      start = 1'b0;
      check("basic_busy_e0", busy, 1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("basic_busy", busy, 1);
         check("basic_done_early", done, 0);
      end
      cyc();
      check("basic_done", done, 1);
      check("basic_busy_end", busy, 0);
      check("basic_product", product, 143);
      cyc();
      check("basic_done_width", done, 0);

      run_mult(4'd15, 4'd15, 8'd225, "c15x15");
      run_mult(4'd0,  4'd9,  8'd0,   "c0x9");
      run_mult(4'd9,  4'd0,  8'd0,   "c9x0");
      run_mult(4'd1,  4'd1,  8'd1,   "c1x1");
      for (int i = 0; i < 12; i++) begin
         cyc();
         check("idle_done", done, 0);
         check("idle_product", product, 1);
      end

      // Back-to-back with start held; operand changes while busy are ignored.
      wait_t5();
      a = 4'd7; b = 4'd9; start = 1'b1;
      cyc();
      a = 4'd15; b = 4'd15;
      check("b2b_busy_e0", busy, 1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("b2b_busy", busy, 1);
      end
      cyc();
      check("b2b_done1", done, 1);
      check("b2b_product1", product, 63);
      t_first = cycle;
      a = 4'd3; b = 4'd5;
      cyc();
      start = 1'b0;
      check("b2b_done1_width", done, 0);
      check("b2b_busy2", busy, 1);
      for (int i = 0; i < 4; i++) cyc();
      cyc();
      check("b2b_done2", done, 1);
      check("b2b_product2", product, 15);
      check("b2b_spacing", cycle - t_first, 6);
      cyc();

      // start during T2 while idle must be ignored.
      for (int i = 0; i < 6 && T != 6'b000100; i++) cyc();
      a = 4'd2; b = 4'd2; start = 1'b1;
      cyc();
      start = 1'b0;
      check("t2_start_busy", busy, 0);
      for (int i = 0; i < 6; i++) cyc();
      check("t2_start_product", product, 15);

      // Asynchronous reset while T2 is the pending phase of 12 x 12.
      wait_t5();
      a = 4'd12; b = 4'd12; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      check("arst_pre_busy", busy, 1);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_product", product, 0);
      check("arst_err", err, 0);
      check("arst_product_nochk", product0, 0);
      @(negedge clk);
      rstn = 1'b1;
      T = 6'b100000;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check("arst_no_done", done, 0);
         check("arst_no_done_nochk", done0, 0);
      end

      // Multi-hot T while idle.
      wait_t5();
      T = 6'b000011;
      @(posedge clk);
      #1;
      cycle++;
      check("illegal_err", err, 1);
      check("illegal_err_nochk", err0, 0);
      check("illegal_busy", busy, 0);
      T = 6'b100000;
      for (int i = 0; i < 6; i++) cyc();
      check("illegal_err_sticky", err, 1);

      run_mult(4'd6, 4'd7, 8'd42, "pre_abort");

      // Ring restart (T5) where T3 was due.
      wait_t5();
      a = 4'd5; b = 4'd5; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      T = 6'b100000;
      @(posedge clk);
      #1;
      cycle++;
      check("abort_busy", busy, 0);
      check("abort_busy_nochk", busy0, 0);
      check("abort_err", err, 1);
      check("abort_err_nochk", err0, 0);
      T = 6'b010000;
      for (int i = 0; i < 7; i++) begin
         cyc();
         check("abort_no_done", done, 0);
         check("abort_no_done_nochk", done0, 0);
      end
      check("abort_product", product, 42);
      check("abort_product_nochk", product0, 42);
      check("abort_err_nochk_end", err0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ring_timed_multiplier.md
# ring_timed_multiplier

Unsigned 4x4 shift-and-add multiplier that sits directly downstream of the 6-phase ring counter. It consumes the one-hot timing vector T[5:0], which runs T5 -> T4 -> ... -> T0 -> T5 and is 100000 after reset. Each phase selects one micro-step: load, four add/shift steps, then result store. One product is finished per ring revolution, so back-to-back operation runs at one result every 6 clocks.

## Interface
- CHECK_ONEHOT, default 1: when 1, illegal T patterns are detected and flagged on err. When 0, no checking is done and err is tied to 0.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- T  input  6  one-hot timing phases from the ring counter; T[5] is the first phase.
- start  input  1  request to multiply; sampled only in phase T5 while idle.
- a  input  4  multiplicand; captured on an accepted start.
- b  input  4  multiplier; captured on an accepted start.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse when product updates.
- product  output  8  last completed result; holds until the next completion.
- err  output  1  sticky flag for a timing-sequence fault.

## Operation
- Internal registers:
  - A[3:0] (multiplicand)
  - Q[3:0] (multiplier/low half)
  - ACC[3:0] (high half)
  - C (carry)
  - state IDLE/RUN
- IDLE, T[5]=1, start=1:
  - A<=a, Q<=b, ACC<=0, C<=0
  - busy<=1, state<=RUN
- IDLE, any other case: hold; start is ignored.
- RUN, phases T[4], T[3], T[2], T[1], each:
  - sum = Q[0] ? ACC+A (5-bit) : {0,ACC}
  - then {C,ACC,Q} <= {sum,Q} >> 1, so C is cleared after the shift.
- RUN, phase T[0]:
  - product<={ACC,Q}, done<=1
  - busy<=0, state<=IDLE
- done defaults to 0 on every edge where it is not being set, so it is exactly one cycle wide.
- start is ignored while busy; operands may change freely after acceptance.
- Arithmetic is exact for all operands (max 15x15=225 fits in 8 bits), with no overflow.
- Sequence fault, RUN only: T[5]=1 while in RUN (e.g. ring restarted).
  - Abort: state<=IDLE, busy<=0, no done, product unchanged.
  - If CHECK_ONEHOT=1, err<=1.
- Illegal T (CHECK_ONEHOT=1): T==0 or more than one bit set, in any state.
  - err<=1.
  - If in RUN, abort as above.
  - Nothing is loaded that cycle.
- CHECK_ONEHOT=0: err is constant 0. T is decoded with priority T[5] > T[4] > ... > T[0]. T==0 holds all state.
- err is sticky; only rstn clears it.

## Timing
- Reset values (asynchronous, immediate on rstn low): busy=0, done=0, product=0, err=0; A, Q, ACC, C=0; state=IDLE.
- Reset mid-operation discards the operation; no done is produced.
- The first ring phase after reset is T5, so start may be accepted at the first edge after rstn rises.
- Latency:
  - start is accepted at edge E0 (T=100000).
  - busy is high from E0 to E5.
  - done=1 and product valid after E5 (T=000001 edge).
  - done is high for the cycle in which T=100000 again.
- Back-to-back: in the done cycle the block is IDLE with T[5]=1, so a new start is accepted at the next edge. Throughput is 1 result per 6 clocks.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and basic:
  - Hold rstn=0: all outputs 0.
  - Release with T=100000, start=1, a=13, b=11.
  - Expect busy for 5 cycles, then a done pulse of exactly 1 cycle with product=143.
- Corners, each run separately:
  - a=15, b=15 -> 225 (carry path exercised).
  - a=0, b=9 -> 0.
  - a=9, b=0 -> 0.
  - a=1, b=1 -> 1.
  - Afterwards product holds its value and done stays 0 for the next 12 idle cycles.
- Back-to-back and ignore:
  - Hold start=1 with a=7, b=9 for the first operation, then a=3, b=5 during the done cycle.
  - Expect 63 then 15, with done pulses 6 cycles apart.
  - Operand changes while busy have no effect.
  - start asserted in a T2 phase while idle is not accepted.
- Async reset mid-run: assert rstn low during phase T2 of 12x12.
  - busy, product and err go to 0 immediately, with no clock needed.
  - No done appears after release.
- Faults with CHECK_ONEHOT=1:
  - Drive T=000011 while idle -> err=1, which stays 1 after legal phases resume.
  - Force T=100000 during phase T3 of a run -> busy drops, no done, product keeps its old value.
  - Repeat with CHECK_ONEHOT=0 -> err stays 0.
